gate_tt_checker: RTL and testbench

GATE_TT_CHECKER -- requirements
Module: gate_tt_checker

---
 rtl/gate_tt_pkg.sv | 15 +
 rtl/gate_tt_checker.sv | 161 ++++++++++++++++
 tb/tb_gate_tt_checker.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/gate_tt_pkg.sv
// Shared types and widths for the two-input gate truth-table checker.
package gate_tt_pkg;

    localparam int TT_W  = 4;
    localparam int IDX_W = 2;
    localparam int ERR_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        CHECK,
        FIN
    } state_t;

endpackage

// File: rtl/gate_tt_checker.sv
// Walks a two-input gate through all four input combinations, lets each
// vector settle for SETTLE_CYCLES, and compares the response with an
// expected truth table, reporting mismatch count and first failing index.
// Optional feature: define GATE_TT_CHECKER_OBS_EN to add the observed_tt
// output that records the gate response seen for every vector.
module gate_tt_checker
    import gate_tt_pkg::*;
#(
    parameter logic [TT_W-1:0] EXPECTED_TT   = 4'b0001,
    parameter int              SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             gate_a,
    output logic             gate_b,
    input  logic             gate_y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [IDX_W-1:0] first_fail_idx
`ifdef GATE_TT_CHECKER_OBS_EN
    ,
    output logic [TT_W-1:0]  observed_tt
`endif
);

    // A zero settle time would sample the gate in the same cycle it changes.
    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("gate_tt_checker: SETTLE_CYCLES must be >= 1");
    end

    localparam int WAIT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(TT_W - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [ERR_W-1:0]   err_count_q, err_count_d;
    logic [IDX_W-1:0]   first_fail_idx_q, first_fail_idx_d;
    logic               pass_q, pass_d;
    logic               gate_a_q, gate_a_d;
    logic               gate_b_q, gate_b_d;
    logic               mismatch;
`ifdef GATE_TT_CHECKER_OBS_EN
    logic [TT_W-1:0]    observed_tt_q, observed_tt_d;
`endif

    // Next-state and datapath updates; stimulus flops follow the next idx so
    // the gate inputs are driven straight from registers.
    always_comb begin
        state_d          = state_q;
        idx_d            = idx_q;
        wait_cnt_d       = wait_cnt_q;
        err_count_d      = err_count_q;
        first_fail_idx_d = first_fail_idx_q;
        pass_d           = pass_q;
`ifdef GATE_TT_CHECKER_OBS_EN
        observed_tt_d    = observed_tt_q;
`endif
        mismatch         = (gate_y !== EXPECTED_TT[idx_q]);

        case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d            = '0;
                    wait_cnt_d       = '0;
                    err_count_d      = '0;
                    pass_d           = 1'b0;
                    first_fail_idx_d = '0;
`ifdef GATE_TT_CHECKER_OBS_EN
                    observed_tt_d    = '0;
`endif
                    state_d          = APPLY;
                end
            end
            APPLY: begin
                wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                if (wait_cnt_q == WAIT_LAST) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (mismatch) begin
                    err_count_d = err_count_q + ERR_W'(1);
                    if (err_count_q == '0) begin
                        first_fail_idx_d = idx_q;
                    end
                end
`ifdef GATE_TT_CHECKER_OBS_EN
                observed_tt_d[idx_q] = gate_y;
`endif
                if (idx_q == IDX_LAST) begin
                    state_d = FIN;
                end else begin
                    idx_d      = idx_q + IDX_W'(1);
                    wait_cnt_d = '0;
                    state_d    = APPLY;
                end
            end
            FIN: begin
                pass_d  = (err_count_q == '0);
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if ((state_d == APPLY) || (state_d == CHECK)) begin
            gate_a_d = idx_d[1];
            gate_b_d = idx_d[0];
        end else begin
            gate_a_d = 1'b0;
            gate_b_d = 1'b0;
        end
    end

    // State register; reset aborts any run in progress without a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            idx_q            <= '0;
            wait_cnt_q       <= '0;
            err_count_q      <= '0;
            first_fail_idx_q <= '0;
            pass_q           <= 1'b0;
            gate_a_q         <= 1'b0;
            gate_b_q         <= 1'b0;
`ifdef GATE_TT_CHECKER_OBS_EN
            observed_tt_q    <= '0;
`endif
        end else begin
            state_q          <= state_d;
            idx_q            <= idx_d;
            wait_cnt_q       <= wait_cnt_d;
            err_count_q      <= err_count_d;
            first_fail_idx_q <= first_fail_idx_d;
            pass_q           <= pass_d;
            gate_a_q         <= gate_a_d;
            gate_b_q         <= gate_b_d;
`ifdef GATE_TT_CHECKER_OBS_EN
            observed_tt_q    <= observed_tt_d;
`endif
        end
    end

    assign gate_a         = gate_a_q;
    assign gate_b         = gate_b_q;
    assign busy           = (state_q == APPLY) || (state_q == CHECK);
    assign done           = (state_q == FIN);
    assign pass           = pass_q;
    assign err_count      = err_count_q;
    assign first_fail_idx = first_fail_idx_q;
`ifdef GATE_TT_CHECKER_OBS_EN
    assign observed_tt    = observed_tt_q;
`endif

endmodule

// File: tb/tb_gate_tt_checker.sv
// Testbench for gate_tt_checker: models several gates-under-test, queues
// the expected result of every run and checks it when done pulses.
// Honours GATE_TT_CHECKER_OBS_EN when the design is built with it.
module tb_gate_tt_checker;
    import gate_tt_pkg::*;

    localparam int DONE_OFS = 12;

    localparam int M_NOR  = 0;
    localparam int M_TIE0 = 1;
    localparam int M_OR   = 2;
    localparam int M_TIE1 = 3;
    localparam int M_XNOR = 4;

    typedef struct {
        int               done_edge;
        logic [ERR_W-1:0] err;
        logic [IDX_W-1:0] ffi;
        logic             pass;
        logic [TT_W-1:0]  obs;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             gate_a, gate_b, gate_y;
    logic             busy, done, pass;
    logic [ERR_W-1:0] err_count;
    logic [IDX_W-1:0] first_fail_idx;
`ifdef GATE_TT_CHECKER_OBS_EN
    logic [TT_W-1:0]  observed_tt;
`endif

    int   mode = M_NOR;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];
    logic pass_pending = 1'b0;
    logic pass_exp = 1'b0;

    gate_tt_checker #(
        .EXPECTED_TT   (4'b0001),
        .SETTLE_CYCLES (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .gate_a         (gate_a),
        .gate_b         (gate_b),
        .gate_y         (gate_y),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .first_fail_idx (first_fail_idx)
`ifdef GATE_TT_CHECKER_OBS_EN
        ,
        .observed_tt    (observed_tt)
`endif
    );

    // Free-running clock and edge counter used to time done pulses.
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Gate-under-test model selected by the current mode.
    always_comb begin
        gate_y = 1'b0;
        case (mode)
            M_NOR:   gate_y = ~(gate_a | gate_b);
            M_TIE0:  gate_y = 1'b0;
            M_OR:    gate_y = gate_a | gate_b;
            M_TIE1:  gate_y = 1'b1;
            M_XNOR:  gate_y = ~(gate_a ^ gate_b);
            default: gate_y = 1'b0;
        endcase
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // Queues the expected outcome and issues a single start pulse.
    task automatic applyStimulus(input int m, input logic [ERR_W-1:0] e_err,
                                 input logic [IDX_W-1:0] e_ffi, input logic e_pass,
                                 input logic [TT_W-1:0] e_obs);
        exp_t e;
        mode = m;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        e.done_edge = cyc + DONE_OFS;
        e.err  = e_err;
        e.ffi  = e_ffi;
        e.pass = e_pass;
        e.obs  = e_obs;
        sb.push_back(e);
    endtask

    // Waits (bounded) for all queued runs to be checked.
    task automatic waitDrain();
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (sb.size() == 0 && !pass_pending && !busy && !done) break;
        end
        checkOutput("drain_queue", sb.size(), 0);
    endtask

    // Monitor: checks each done pulse against the scoreboard, then pass a cycle later.
    always @(negedge clk) begin
        if (pass_pending) begin
            checkOutput("pass", pass, pass_exp);
            pass_pending = 1'b0;
        end
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_done", done, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("done_edge", cyc, e.done_edge);
                checkOutput("err_count", err_count, e.err);
                checkOutput("first_fail_idx", first_fail_idx, e.ffi);
`ifdef GATE_TT_CHECKER_OBS_EN
                checkOutput("observed_tt", observed_tt, e.obs);
`endif
                pass_exp     = e.pass;
                pass_pending = 1'b1;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL global_timeout: got running expected finished");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        int base;
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_pass", pass, 0);
        checkOutput("rst_err", err_count, 0);
        checkOutput("rst_ffi", first_fail_idx, 0);
        checkOutput("rst_gate_a", gate_a, 0);
        checkOutput("rst_gate_b", gate_b, 0);
        rst = 1'b0;

        // NOR with start pulses while busy and during FIN, which must be ignored.
        applyStimulus(M_NOR, 3'd0, 2'd0, 1'b1, 4'b0001);
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            start = (k == 4 || k == 9 || k == 12 || k == 13);
        end
        @(negedge clk);
        start = 1'b0;
        waitDrain();

        applyStimulus(M_TIE0, 3'd1, 2'd0, 1'b0, 4'b0000);
        waitDrain();
        applyStimulus(M_OR, 3'd4, 2'd0, 1'b0, 4'b1110);
        waitDrain();
        applyStimulus(M_XNOR, 3'd1, 2'd3, 1'b0, 4'b1001);
        waitDrain();
        applyStimulus(M_TIE1, 3'd3, 2'd1, 1'b0, 4'b1111);
        waitDrain();

        // Results must hold while idle.
        repeat (5) @(negedge clk);
        checkOutput("hold_err", err_count, 3);
        checkOutput("hold_ffi", first_fail_idx, 1);
        checkOutput("hold_pass", pass, 0);

        // Start held high: back-to-back runs accepted every 14 edges.
        mode = M_NOR;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        base = cyc;
        for (int r = 0; r < 3; r++) begin
            exp_t e;
            e.done_edge = base + DONE_OFS + 14 * r;
            e.err  = 3'd0;
            e.ffi  = 2'd0;
            e.pass = 1'b1;
            e.obs  = 4'b0001;
            sb.push_back(e);
        end
        repeat (39) @(posedge clk);
        #1;
        start = 1'b0;
        waitDrain();

        // Reset in cycle 6 of a run aborts it with no done pulse.
        mode = M_TIE0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("pre_rst_err", err_count, 1);
        checkOutput("pre_rst_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_gate_a", gate_a, 0);
        checkOutput("abort_gate_b", gate_b, 0);
        checkOutput("abort_err", err_count, 0);
        checkOutput("abort_done", done, 0);

        // Reset wins over start in the same cycle.
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        checkOutput("rst_over_start_busy", busy, 0);
        @(negedge clk);
        checkOutput("rst_over_start_busy2", busy, 0);
        repeat (20) @(negedge clk);
        checkOutput("abort_no_done_queue", sb.size(), 0);

        // A fresh run after the abort still works.
        applyStimulus(M_OR, 3'd4, 2'd0, 1'b0, 4'b1110);
        waitDrain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
